// File: rtl/sniffer_pkg.sv
// Shared types and constants for the frame sniffer: controller state encoding,
// IP width, comparator drain depth and the largest frame in words.
package sniffer_pkg;
    localparam int IP_W            = 32;
    localparam int DRAIN_CYCLES    = 4;
    localparam int MAX_FRAME_WORDS = 375;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } ctl_state_t;
endpackage

// File: rtl/ip_cfg_bank.sv
// Shadow/active register pair for the comparator IP entries. Software writes the
// shadow at any time; the active copy only changes on the copy strobe.
module ip_cfg_bank
    import sniffer_pkg::*;
#(
    parameter int NUM_IPS = 4,
    parameter int IDX_W   = 2
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    i_we,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic [IP_W-1:0]         i_ip,
    input  logic                    i_en,
    input  logic                    i_copy,
    output logic [NUM_IPS*IP_W-1:0] o_act_ip,
    output logic [NUM_IPS-1:0]      o_act_en
);
    logic [IP_W-1:0]    r_sh_ip     [NUM_IPS];
    logic [NUM_IPS-1:0] r_sh_en;
    logic [IP_W-1:0]    r_act_ip    [NUM_IPS];
    logic [NUM_IPS-1:0] r_act_en;
    logic [IP_W-1:0]    w_sh_ip_nxt [NUM_IPS];
    logic [NUM_IPS-1:0] w_sh_en_nxt;

    // The copy takes the post-write shadow so a write landing with the copy is kept.
    always_comb begin
        w_sh_en_nxt = r_sh_en;
        for (int i = 0; i < NUM_IPS; i++) begin
            w_sh_ip_nxt[i] = r_sh_ip[i];
            if (i_we && (i_idx == IDX_W'(i))) begin
                w_sh_ip_nxt[i] = i_ip;
                w_sh_en_nxt[i] = i_en;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_IPS; i++) begin
                r_sh_ip[i]  <= '0;
                r_act_ip[i] <= '0;
            end
            r_sh_en  <= '0;
            r_act_en <= '0;
        end else begin
            for (int i = 0; i < NUM_IPS; i++) begin
                r_sh_ip[i] <= w_sh_ip_nxt[i];
                if (i_copy) r_act_ip[i] <= w_sh_ip_nxt[i];
            end
            r_sh_en <= w_sh_en_nxt;
            if (i_copy) r_act_en <= w_sh_en_nxt;
        end
    end

    always_comb begin
        o_act_ip = '0;
        for (int i = 0; i < NUM_IPS; i++) begin
            o_act_ip[i*IP_W +: IP_W] = r_act_ip[i];
        end
    end

    assign o_act_en = r_act_en;
endmodule

// File: rtl/ip_match_controller.sv
// Frame sequencer for the IP comparator bank: clears and loads the bank at sop,
// streams registered words, drains comparator latency, then holds one result.
module ip_match_controller
    import sniffer_pkg::*;
#(
    parameter int NUM_IPS   = 4,
    parameter int MAX_WORDS = MAX_FRAME_WORDS,
    parameter int CNT_W     = 9,
    parameter int IDX_W     = 2
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_idx,
    input  logic [IP_W-1:0]         cfg_ip,
    input  logic                    cfg_en,
    input  logic                    in_valid,
    input  logic                    in_sop,
    input  logic                    in_eop,
    input  logic [IP_W-1:0]         in_data,
    output logic                    in_ready,
    output logic                    cmp_clear,
    output logic [IP_W-1:0]         cmp_data,
    output logic [NUM_IPS*IP_W-1:0] cmp_ip,
    input  logic [NUM_IPS-1:0]      cmp_match,
    output logic                    result_valid,
    output logic [NUM_IPS-1:0]      result_match,
    output logic [CNT_W-1:0]        result_words,
    output logic                    result_err,
    input  logic                    result_ack,
    output ctl_state_t              dbg_state
);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES);

    ctl_state_t         r_state, w_state_nxt;
    logic               w_sop_acc, w_drain_done;
    logic [IP_W-1:0]    r_cmp_data;
    logic [CNT_W-1:0]   r_count, r_res_words;
    logic               r_err, r_res_err;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [NUM_IPS-1:0] r_res_match, w_act_en;

    ip_cfg_bank #(.NUM_IPS(NUM_IPS), .IDX_W(IDX_W)) u_cfg_bank (
        .clk      (clk),
        .n_rst    (n_rst),
        .i_we     (cfg_we),
        .i_idx    (cfg_idx),
        .i_ip     (cfg_ip),
        .i_en     (cfg_en),
        .i_copy   (w_sop_acc),
        .o_act_ip (cmp_ip),
        .o_act_en (w_act_en)
    );

    assign w_sop_acc    = (r_state == ST_IDLE) && in_valid && in_sop;
    assign w_drain_done = (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));

    // Beats are accepted (in_valid && in_ready) in IDLE and RECV; HOLD releases on result_ack.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        cmp_clear   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (w_sop_acc) begin
                    cmp_clear   = 1'b1;
                    w_state_nxt = in_eop ? ST_DRAIN : ST_RECV;
                end
            end
            ST_RECV: begin
                in_ready = 1'b1;
                if (in_valid && !in_sop && in_eop) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (w_drain_done) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (result_ack) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Any cycle without an accepted in-frame word feeds zeros so no stale straddle survives.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cmp_data  <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_drain_cnt <= '0;
            r_res_match <= '0;
            r_res_words <= '0;
            r_res_err   <= 1'b0;
        end else begin
            r_cmp_data <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sop_acc) begin
                        r_cmp_data  <= in_data;
                        r_count     <= CNT_W'(1);
                        r_err       <= 1'b0;
                        r_drain_cnt <= '0;
                    end
                end
                ST_RECV: begin
                    r_drain_cnt <= '0;
                    if (!in_valid || in_sop) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cmp_data <= in_data;
                        if (r_count == CNT_W'(MAX_WORDS)) r_err   <= 1'b1;
                        else                              r_count <= r_count + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + 1'b1;
                    if (w_drain_done) begin
                        r_res_match <= r_err ? '0 : (cmp_match & w_act_en);
                        r_res_words <= r_count;
                        r_res_err   <= r_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmp_data     = r_cmp_data;
    assign result_valid = (r_state == ST_HOLD);
    assign result_match = r_res_match;
    assign result_words = r_res_words;
    assign result_err   = r_res_err;
    assign dbg_state    = r_state;
endmodule

// File: tb/tb_ip_match_controller.sv
// Randomised and directed bench for ip_match_controller with a byte-search
// reference model, a behavioural comparator bank and a result scoreboard.
module tb_ip_match_controller;
    import sniffer_pkg::*;

    localparam int NUM_IPS = 4;
    localparam int CNT_W   = 9;
    localparam int IDX_W   = 2;
    localparam int MAXW    = 375;
    localparam int W       = NUM_IPS + CNT_W + 1;

    logic                    clk = 1'b0;
    logic                    n_rst = 1'b0;
    logic                    cfg_we = 1'b0, cfg_en = 1'b0;
    logic [IDX_W-1:0]        cfg_idx = '0;
    logic [31:0]             cfg_ip = '0, in_data = '0;
    logic                    in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic                    in_ready, cmp_clear, result_valid, result_err;
    logic                    result_ack = 1'b0;
    logic [31:0]             cmp_data;
    logic [NUM_IPS*32-1:0]   cmp_ip;
    logic [NUM_IPS-1:0]      cmp_match, result_match;
    logic [CNT_W-1:0]        result_words;
    ctl_state_t              dbg_state;

    ip_match_controller #(.NUM_IPS(NUM_IPS), .MAX_WORDS(MAXW), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .n_rst(n_rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_ip(cfg_ip),
        .cfg_en(cfg_en), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_data(in_data), .in_ready(in_ready), .cmp_clear(cmp_clear), .cmp_data(cmp_data),
        .cmp_ip(cmp_ip), .cmp_match(cmp_match), .result_valid(result_valid),
        .result_match(result_match), .result_words(result_words), .result_err(result_err),
        .result_ack(result_ack), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- comparator bank stand-in: 3-stage sticky matcher ----------------
    logic [31:0]        cm_prev;
    logic [NUM_IPS-1:0] cm_s1, cm_s2, cm_match;

    function automatic logic [NUM_IPS-1:0] window_hits(input logic [31:0] prev, input logic [31:0] cur,
                                                       input logic [NUM_IPS*32-1:0] ips);
        logic [63:0] win;
        logic [NUM_IPS-1:0] hits;
        win  = {prev, cur};
        hits = '0;
        for (int i = 0; i < NUM_IPS; i++)
            for (int k = 0; k <= 4; k++)
                if (win[63-8*k -: 32] == ips[32*i +: 32]) hits[i] = 1'b1;
        return hits;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst || cmp_clear) begin
            cm_prev <= '0; cm_s1 <= '0; cm_s2 <= '0; cm_match <= '0;
        end else begin
            cm_prev  <= cmp_data;
            cm_s1    <= window_hits(cm_prev, cmp_data, cmp_ip);
            cm_s2    <= cm_s1;
            cm_match <= cm_match | cm_s2;
        end
    end
    assign cmp_match = cm_match;

    // ---------------- reference model ----------------
    logic [31:0]        sh_ip [NUM_IPS];
    logic [NUM_IPS-1:0] sh_en = '0;

    function automatic logic [7:0] frame_byte(input logic [31:0] words[$], input int j);
        logic [31:0] w;
        w = words[j/4];
        return w[31-8*(j%4) -: 8];
    endfunction

    function automatic bit has_ip(input logic [31:0] words[$], input logic [31:0] ip);
        logic [31:0] win;
        int nb;
        nb = words.size() * 4;
        for (int p = 0; p + 4 <= nb; p++) begin
            for (int k = 0; k < 4; k++) win[31-8*k -: 8] = frame_byte(words, p + k);
            if (win == ip) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] ref_result(input logic [31:0] words[$], input bit gap,
                                                input logic [NUM_IPS*32-1:0] ips, input logic [NUM_IPS-1:0] ens);
        int n;
        bit err;
        logic [NUM_IPS-1:0] m;
        logic [CNT_W-1:0] cnt;
        n   = words.size();
        err = gap || (n > MAXW);
        cnt = CNT_W'((n > MAXW) ? MAXW : n);
        m   = '0;
        if (!err)
            for (int i = 0; i < NUM_IPS; i++)
                if (ens[i] && has_ip(words, ips[32*i +: 32])) m[i] = 1'b1;
        return {m, cnt, err};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           eop_q[$];
    int           n_cmp = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    bit mon_prev_v = 1'b0;
    always @(negedge clk) begin
        if (n_rst && result_valid && !mon_prev_v) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(result_valid), 64'(0));
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("result_match", 64'(result_match), 64'(e[W-1 -: NUM_IPS]));
                check("result_words", 64'(result_words), 64'(e[CNT_W:1]));
                check("result_err",   64'(result_err),   64'(e[0]));
                if (eop_q.size() > 0) check("result_latency", 64'(cyc), 64'(eop_q.pop_front() + 5));
            end
        end
        mon_prev_v = result_valid;
    end

    // ---------------- driver tasks ----------------
    int          cw_at = -1, cw_idx = 0;
    logic [31:0] cw_ip = '0;
    bit          cw_en = 1'b0;

    task automatic cfg_write(input int idx, input logic [31:0] ip, input bit en);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_ip = ip; cfg_en = en;
        sh_ip[idx] = ip; sh_en[idx] = en;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] words[$], input int gap_after, input bit push);
        logic [NUM_IPS*32-1:0] ip_snap;
        logic [NUM_IPS-1:0]    en_snap;
        int n;
        n = words.size();
        ip_snap = '0; en_snap = '0;
        for (int b = 0; b < n; b++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_sop = (b == 0); in_eop = (b == n - 1); in_data = words[b];
            cfg_we = 1'b0;
            if (b == cw_at) begin
                cfg_we = 1'b1; cfg_idx = IDX_W'(cw_idx); cfg_ip = cw_ip; cfg_en = cw_en;
                sh_ip[cw_idx] = cw_ip; sh_en[cw_idx] = cw_en;
            end
            if (b == 0) begin
                for (int i = 0; i < NUM_IPS; i++) ip_snap[32*i +: 32] = sh_ip[i];
                en_snap = sh_en;
                #1 check("sop_clear", 64'(cmp_clear), 64'(1));
            end
            if (b == n - 1 && push) eop_q.push_back(cyc);
            if (b == gap_after && b != n - 1) begin
                @(posedge clk); #1;
                in_valid = 1'b0; cfg_we = 1'b0;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; cfg_we = 1'b0;
        cw_at = -1;
        if (push) exp_q.push_back(ref_result(words, (gap_after >= 0) && (gap_after < n - 1), ip_snap, en_snap));
    endtask

    task automatic wait_res(output bit ok);
        int t;
        t = 0;
        while (!result_valid && t < 60) begin @(negedge clk); t++; end
        ok = result_valid;
        if (!ok) check("result_timeout", 64'(result_valid), 64'(1));
    endtask

    task automatic do_ack(input int delay);
        repeat (delay) @(posedge clk);
        @(posedge clk); #1; result_ack = 1'b1;
        @(posedge clk); #1; result_ack = 1'b0;
        @(negedge clk);
        check("ack_valid_low", 64'(result_valid), 64'(0));
        check("ack_ready_high", 64'(in_ready), 64'(1));
    endtask

    task automatic expect_res(input logic [NUM_IPS-1:0] m, input int words, input bit err);
        check("dir_match", 64'(result_match), 64'(m));
        check("dir_words", 64'(result_words), 64'(words));
        check("dir_err",   64'(result_err),   64'(err));
    endtask

    function automatic logic [31:0] rand_word();
        return {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
                8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] fr[$];
        bit ok;
        for (int i = 0; i < NUM_IPS; i++) sh_ip[i] = '0;

        #2;
        check("rst_valid", 64'(result_valid), 64'(0));
        check("rst_words", 64'(result_words), 64'(0));
        check("rst_cmp_ip", 64'(cmp_ip[63:0]), 64'(0));
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(in_ready), 64'(1));

        // aligned match
        cfg_write(0, 32'hC0A8010A, 1'b1);
        fr = '{32'h11223344, 32'hC0A8010A, 32'h55667788};
        send_frame(fr, -1, 1'b1);
        wait_res(ok); if (ok) expect_res(4'b0001, 3, 1'b0);
        do_ack(0);

        // straddled match, then with the entry disabled
        fr = '{32'h1122C0A8, 32'h010A3344};
        send_frame(fr, -1, 1'b1);
        wait_res(ok); if (ok) expect_res(4'b0001, 2, 1'b0);
        do_ack(1);
        cfg_write(0, 32'hC0A8010A, 1'b0);
        send_frame(fr, -1, 1'b1);
        wait_res(ok); if (ok) expect_res(4'b0000, 2, 1'b0);
        do_ack(0);

        // gap after word 1
        cfg_write(0, 32'hC0A8010A, 1'b1);
        fr = '{32'h11223344, 32'hC0A8010A, 32'h55667788};
        send_frame(fr, 0, 1'b1);
        wait_res(ok); if (ok) expect_res(4'b0000, 3, 1'b1);
        do_ack(0);

        // config staged mid-frame applies to the next frame only
        fr = '{32'h0A000001, 32'h11223344, 32'h55667788};
        cw_at = 1; cw_idx = 1; cw_ip = 32'h0A000001; cw_en = 1'b1;
        send_frame(fr, -1, 1'b1);
        wait_res(ok); if (ok) expect_res(4'b0000, 3, 1'b0);
        do_ack(0);
        send_frame(fr, -1, 1'b1);
        wait_res(ok); if (ok) expect_res(4'b0010, 3, 1'b0);

        // backpressure: result held, a sop offered in HOLD is dropped
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = (i == 4); in_sop = (i == 4); in_eop = (i == 4); in_data = 32'hC0A8010A;
            #1 check("hold_no_clear", 64'(cmp_clear), 64'(0));
            @(negedge clk);
            check("hold_valid", 64'(result_valid), 64'(1));
            check("hold_ready", 64'(in_ready), 64'(0));
            check("hold_words", 64'(result_words), 64'(3));
        end
        @(posedge clk); #1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        do_ack(0);

        // oversize frame
        fr = {};
        for (int i = 0; i < 400; i++) fr.push_back(rand_word());
        send_frame(fr, -1, 1'b1);
        wait_res(ok); if (ok) expect_res(4'b0000, MAXW, 1'b1);
        do_ack(0);

        // randomised frames
        for (int f = 0; f < 30; f++) begin
            int n, gap;
            if (f % 5 == 0) cfg_write($urandom_range(2, 3), rand_word(), 1'($urandom_range(0, 1)));
            n = $urandom_range(1, 10);
            fr = {};
            for (int i = 0; i < n; i++) fr.push_back(rand_word());
            if ($urandom_range(0, 1) == 1) begin
                int e, p, q, r;
                logic [31:0] ip, w;
                e  = $urandom_range(0, NUM_IPS - 1);
                ip = (sh_ip[e] == 0) ? 32'hC0A8010A : sh_ip[e];
                p  = $urandom_range(0, 4 * n - 4);
                for (int k = 0; k < 4; k++) begin
                    q = (p + k) / 4; r = (p + k) % 4;
                    w = fr[q]; w[31-8*r -: 8] = ip[31-8*k -: 8]; fr[q] = w;
                end
            end
            gap = ($urandom_range(0, 5) == 0 && n > 1) ? $urandom_range(0, n - 2) : -1;
            if ($urandom_range(0, 3) == 0 && n > 1) begin
                cw_at = $urandom_range(1, n - 1); cw_idx = $urandom_range(2, 3);
                cw_ip = rand_word(); cw_en = 1'b1;
            end
            send_frame(fr, gap, 1'b1);
            wait_res(ok);
            do_ack($urandom_range(0, 3));
        end

        // reset during DRAIN
        fr = '{32'hC0A8010A, 32'h11223344};
        send_frame(fr, -1, 1'b0);
        check("pre_rst_drain", 64'(dbg_state), 64'(ST_DRAIN));
        #2 n_rst = 1'b0;
        for (int i = 0; i < NUM_IPS; i++) sh_ip[i] = '0;
        sh_en = '0;
        #1;
        check("mid_rst_valid", 64'(result_valid), 64'(0));
        check("mid_rst_words", 64'(result_words), 64'(0));
        check("mid_rst_match", 64'(result_match), 64'(0));
        check("mid_rst_cmp_data", 64'(cmp_data), 64'(0));
        check("mid_rst_cmp_ip", 64'(cmp_ip[63:0]), 64'(0));
        check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(in_ready), 64'(1));

        cfg_write(0, 32'hC0A8010A, 1'b1);
        fr = '{32'h11223344, 32'hC0A8010A};
        send_frame(fr, -1, 1'b1);
        wait_res(ok); if (ok) expect_res(4'b0001, 2, 1'b0);
        do_ack(0);

        repeat (10) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
